clock_enable_ctrl: RTL and testbench

Per-domain clock-enable sequencer that sits directly upstream of the clock manager and drives its `enable_fir`, `enable_fft` and `enable_dma` inputs. Each domain has a request/acknowledge handshake with the task scheduler and a busy input from its engine. A domain's clock is started on request, acknowledged after a fixed wake-up delay, and stopped after an idle timeout. The DMA clock is held on whenever the FIR or FFT domain is active.

---
 rtl/clk_ctrl_pkg.sv | 24 ++
 rtl/clk_domain_fsm.sv | 109 ++++++++++
 rtl/clock_enable_ctrl.sv | 86 ++++++++
 tb/tb_clock_enable_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the per-domain clock-enable sequencer.
// State encoding, domain indices and a counter-width helper.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } dom_state_t;

    localparam int FIR         = 0;
    localparam int FFT         = 1;
    localparam int DMA         = 2;
    localparam int NUM_DOMAINS = 3;

    // The down-counter only ever holds load values, i.e. max(a,b)-1.
    function automatic int cnt_bits(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clk_domain_fsm.sv
// One clock domain: OFF/WAKE/ON/DRAIN sequencer with wake and idle countdown.
// Optional on-cycle statistics counter when CLK_EN_STATS_EN is defined.
module clk_domain_fsm
    import clk_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             busy_i,
`ifdef CLK_EN_STATS_EN
    input  logic             stats_clr_i,
    output logic [CNT_W-1:0] on_cycles_o,
`endif
    output logic             enable_o,
    output logic             ack_o,
    output dom_state_t       state_o
);

    localparam int            CW        = cnt_bits(WAKE_CYCLES, IDLE_TIMEOUT);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_TIMEOUT - 1);

    dom_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          enable_q;
    logic          ack_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (req_i) begin
                        state_q  <= WAKE;
                        enable_q <= 1'b1;
                        cnt_q    <= WAKE_LOAD;
                    end
                end
                WAKE: begin
                    if (cnt_q == '0) begin
                        state_q <= ON;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ON: begin
                    if (!req_i && !busy_i) begin
                        state_q <= DRAIN;
                        ack_q   <= 1'b0;
                        cnt_q   <= IDLE_LOAD;
                    end
                end
                DRAIN: begin
                    // Clock never stopped here, so a re-request skips the wake delay.
                    if (req_i) begin
                        state_q <= ON;
                        ack_q   <= 1'b1;
                    end else if (busy_i) begin
                        cnt_q <= IDLE_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q  <= OFF;
                        enable_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q  <= OFF;
                    enable_q <= 1'b0;
                    ack_q    <= 1'b0;
                end
            endcase
        end
    end

    assign enable_o = enable_q;
    assign ack_o    = ack_q;
    assign state_o  = state_q;

`ifdef CLK_EN_STATS_EN
    logic [CNT_W-1:0] on_cycles_q;
    logic [CNT_W-1:0] on_cycles_d;

    always_comb begin
        on_cycles_d = on_cycles_q;
        if (stats_clr_i)
            on_cycles_d = '0;
        else if (enable_q && (on_cycles_q != '1))
            on_cycles_d = on_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) on_cycles_q <= '0;
        else       on_cycles_q <= on_cycles_d;
    end

    assign on_cycles_o = on_cycles_q;
`endif

endmodule

// File: rtl/clock_enable_ctrl.sv
// Clock-enable sequencer for the FIR, FFT and DMA clock domains; DMA is held
// on while FIR or FFT is active. Optional statistics via CLK_EN_STATS_EN.
module clock_enable_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int WAKE_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             req_fir,
    input  logic             req_fft,
    input  logic             req_dma,
    input  logic             busy_fir,
    input  logic             busy_fft,
    input  logic             busy_dma,
`ifdef CLK_EN_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] on_cycles_fir,
    output logic [CNT_W-1:0] on_cycles_fft,
    output logic [CNT_W-1:0] on_cycles_dma,
`endif
    output logic             enable_fir,
    output logic             enable_fft,
    output logic             enable_dma,
    output logic             ack_fir,
    output logic             ack_fft,
    output logic             ack_dma,
    output logic             all_idle
);

    logic [NUM_DOMAINS-1:0] req_eff;
    logic [NUM_DOMAINS-1:0] busy_v;
    logic [NUM_DOMAINS-1:0] enable_v;
    logic [NUM_DOMAINS-1:0] ack_v;
    dom_state_t             state_v [NUM_DOMAINS];
`ifdef CLK_EN_STATS_EN
    logic [NUM_DOMAINS-1:0][CNT_W-1:0] on_cnt_v;
`endif

    // DMA follows the registered FIR/FFT state, so it lags their enables by one edge.
    assign req_eff[FIR] = req_fir;
    assign req_eff[FFT] = req_fft;
    assign req_eff[DMA] = req_dma | (state_v[FIR] != OFF) | (state_v[FFT] != OFF);

    assign busy_v[FIR] = busy_fir;
    assign busy_v[FFT] = busy_fft;
    assign busy_v[DMA] = busy_dma;

    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
        clk_domain_fsm #(
            .WAKE_CYCLES  (WAKE_CYCLES),
            .IDLE_TIMEOUT (IDLE_TIMEOUT),
            .CNT_W        (CNT_W)
        ) u_fsm (
            .clk_i       (clk_in),
            .rst_i       (reset),
            .req_i       (req_eff[d]),
            .busy_i      (busy_v[d]),
`ifdef CLK_EN_STATS_EN
            .stats_clr_i (stats_clr),
            .on_cycles_o (on_cnt_v[d]),
`endif
            .enable_o    (enable_v[d]),
            .ack_o       (ack_v[d]),
            .state_o     (state_v[d])
        );
    end

    assign enable_fir = enable_v[FIR];
    assign enable_fft = enable_v[FFT];
    assign enable_dma = enable_v[DMA];
    assign ack_fir    = ack_v[FIR];
    assign ack_fft    = ack_v[FFT];
    assign ack_dma    = ack_v[DMA];

`ifdef CLK_EN_STATS_EN
    assign on_cycles_fir = on_cnt_v[FIR];
    assign on_cycles_fft = on_cnt_v[FFT];
    assign on_cycles_dma = on_cnt_v[DMA];
`endif

    assign all_idle = (state_v[FIR] == OFF) && (state_v[FFT] == OFF) && (state_v[DMA] == OFF);

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Bench for clock_enable_ctrl: directed vectors, corner sequences and random
// stimulus against a behavioural model; stats checks when CLK_EN_STATS_EN is set.
module tb_clock_enable_ctrl;

    localparam int WAKE = 2;
    localparam int IDLE = 16;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = '0;
    logic [2:0]    busy = '0;
    logic          clr = 1'b0;
    logic          enable_fir, enable_fft, enable_dma;
    logic          ack_fir, ack_fft, ack_dma, all_idle;
    logic [CW-1:0] on_fir, on_fft, on_dma;
    logic [2:0]    en_v, ack_v;

    always #5 clk = ~clk;

    clock_enable_ctrl #(.WAKE_CYCLES(WAKE), .IDLE_TIMEOUT(IDLE), .CNT_W(CW)) dut (
        .clk_in        (clk),
        .reset         (rst),
        .req_fir       (req[0]),
        .req_fft       (req[1]),
        .req_dma       (req[2]),
        .busy_fir      (busy[0]),
        .busy_fft      (busy[1]),
        .busy_dma      (busy[2]),
`ifdef CLK_EN_STATS_EN
        .stats_clr     (clr),
        .on_cycles_fir (on_fir),
        .on_cycles_fft (on_fft),
        .on_cycles_dma (on_dma),
`endif
        .enable_fir    (enable_fir),
        .enable_fft    (enable_fft),
        .enable_dma    (enable_dma),
        .ack_fir       (ack_fir),
        .ack_fft       (ack_fft),
        .ack_dma       (ack_dma),
        .all_idle      (all_idle)
    );

`ifndef CLK_EN_STATS_EN
    assign on_fir = '0;
    assign on_fft = '0;
    assign on_dma = '0;
`endif

    assign en_v  = {enable_dma, enable_fft, enable_fir};
    assign ack_v = {ack_dma, ack_fft, ack_fir};

    int errs   = 0;
    int checks = 0;

    // Behavioural model: clock running, usable, and a wake-in-progress flag per domain.
    bit m_en [3];
    bit m_ack[3];
    bit m_wake[3];
    int m_cnt[3];
    int m_on [3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_en[d] = 0; m_ack[d] = 0; m_wake[d] = 0; m_cnt[d] = 0; m_on[d] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit r[3];
        r[0] = req[0];
        r[1] = req[1];
        r[2] = req[2] | m_en[0] | m_en[1];
        for (int d = 0; d < 3; d++) begin
            if (clr)                        m_on[d] = 0;
            else if (m_en[d] && m_on[d] < MAXC) m_on[d] = m_on[d] + 1;
            if (!m_en[d]) begin
                if (r[d]) begin m_en[d] = 1; m_wake[d] = 1; m_cnt[d] = WAKE - 1; end
            end else if (m_wake[d]) begin
                if (m_cnt[d] == 0) begin m_wake[d] = 0; m_ack[d] = 1; end
                else m_cnt[d] = m_cnt[d] - 1;
            end else if (m_ack[d]) begin
                if (!r[d] && !busy[d]) begin m_ack[d] = 0; m_cnt[d] = IDLE - 1; end
            end else begin
                if (r[d])              m_ack[d] = 1;
                else if (busy[d])      m_cnt[d] = IDLE - 1;
                else if (m_cnt[d] == 0) m_en[d] = 0;
                else                   m_cnt[d] = m_cnt[d] - 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_en",   {13'd0, en_v},  {13'd0, m_en[2], m_en[1], m_en[0]});
        chk("model_ack",  {13'd0, ack_v}, {13'd0, m_ack[2], m_ack[1], m_ack[0]});
        chk("model_idle", {15'd0, all_idle}, {15'd0, !(m_en[0] | m_en[1] | m_en[2])});
`ifdef CLK_EN_STATS_EN
        chk("model_on_fir", {12'd0, on_fir}, 16'(m_on[0]));
        chk("model_on_fft", {12'd0, on_fft}, 16'(m_on[1]));
        chk("model_on_dma", {12'd0, on_dma}, 16'(m_on[2]));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        req = '0; busy = '0; clr = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] busy;
        logic [2:0] en;
        logic [2:0] ack;
        logic       idle;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // FIR wake from cold, DMA following one edge later, then FIR release.
        vecs[0] = '{3'b001, 3'b000, 3'b001, 3'b000, 1'b0};
        vecs[1] = '{3'b001, 3'b000, 3'b101, 3'b000, 1'b0};
        vecs[2] = '{3'b001, 3'b000, 3'b101, 3'b001, 1'b0};
        vecs[3] = '{3'b001, 3'b000, 3'b101, 3'b101, 1'b0};
        vecs[4] = '{3'b000, 3'b000, 3'b101, 3'b100, 1'b0};

        // Reset state, during and after reset
        model_reset();
        @(negedge clk);
        chk("rst_en",   {13'd0, en_v}, 16'd0);
        chk("rst_ack",  {13'd0, ack_v}, 16'd0);
        chk("rst_idle", {15'd0, all_idle}, 16'd1);
        do_reset();
        @(negedge clk);
        check_model();
        chk("post_rst_idle", {15'd0, all_idle}, 16'd1);

        // Table-driven FIR sequence
        for (int i = 0; i < 5; i++) begin
            req = vecs[i].req; busy = vecs[i].busy;
            step();
            chk("tbl_en",   {13'd0, en_v},  {13'd0, vecs[i].en});
            chk("tbl_ack",  {13'd0, ack_v}, {13'd0, vecs[i].ack});
            chk("tbl_idle", {15'd0, all_idle}, {15'd0, vecs[i].idle});
        end
        for (int k = 1; k <= IDLE - 1; k++) begin
            step();
            chk("fir_drain_hold", {15'd0, enable_fir}, 16'd1);
        end
        step();
        chk("fir_off", {15'd0, enable_fir}, 16'd0);
        repeat (18) step();
        chk("dma_off_after_fir", {15'd0, enable_dma}, 16'd0);
        chk("idle_after_fir", {15'd0, all_idle}, 16'd1);

        // FFT: re-request in DRAIN, busy reload, DMA follow
        do_reset();
        req = 3'b010;
        repeat (3) step();
        chk("fft_ack", {15'd0, ack_fft}, 16'd1);
        req = 3'b000;
        step();
        repeat (3) step();
        req = 3'b010;
        step();
        chk("fft_rereq_ack", {15'd0, ack_fft}, 16'd1);
        req = 3'b000;
        step();
        repeat (12) step();
        chk("fft_pre_busy", {15'd0, enable_fft}, 16'd1);
        busy = 3'b010;
        step();
        busy = 3'b000;
        repeat (IDLE - 1) step();
        chk("fft_reload_hold", {15'd0, enable_fft}, 16'd1);
        step();
        chk("fft_reload_off", {15'd0, enable_fft}, 16'd0);
        chk("dma_follow_on", {15'd0, enable_dma}, 16'd1);
        repeat (IDLE) step();
        chk("dma_drain_hold", {15'd0, enable_dma}, 16'd1);
        step();
        chk("dma_off", {15'd0, enable_dma}, 16'd0);

        // Asynchronous reset mid-WAKE on all domains
        do_reset();
        req = 3'b111;
        step();
        chk("wake_all_en", {13'd0, en_v}, 16'h7);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_en",   {13'd0, en_v}, 16'd0);
        chk("async_rst_ack",  {13'd0, ack_v}, 16'd0);
        chk("async_rst_idle", {15'd0, all_idle}, 16'd1);
        chk("async_rst_stats", {4'd0, on_fir, on_fft, on_dma}, 16'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;

`ifdef CLK_EN_STATS_EN
        do_reset();
        req = 3'b001;
        repeat (20) step();
        chk("on_fir_sat", {12'd0, on_fir}, 16'd15);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("stats_clr", {4'd0, on_fir, on_fft, on_dma}, 16'd0);
        req = '0;
`endif

        // Random stimulus against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 7) == 0) req[d] = ~req[d];
                busy[d] = ($urandom_range(0, 5) == 0);
            end
            clr = ($urandom_range(0, 63) == 0);
            step();
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
